uart_tx_gen: RTL and testbench
==============================

UART_TX_GEN -- requirements
Module: uart_tx_gen

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: transmit FIFO entries; power of two, at least 2.
REQ-002 SHALL have parameter DIV_W, default 16: width of the baud divisor input.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port tx_dv, input, 1: write strobe; pushes tx_byte into the FIFO.
REQ-006 SHALL have port tx_byte, input, 8: data to transmit, LSB first.
REQ-007 SHALL have port tx_ready, output, 1: high when FIFO not full.
REQ-008 SHALL have port data_bits, input, 2: 0=5, 1=6, 2=7, 3=8 data bits.
REQ-009 SHALL have port parity_mode, input, 2: 0=none, 1=even, 2=odd, 3=space (parity bit always 0).
REQ-010 SHALL have port stop_bits, input, 1: 0=one stop bit, 1=two stop bits.
REQ-011 SHALL have port clks_per_bit, input, DIV_W: clk cycles per serial bit; values 0 and 1 treated as 2.
REQ-012 SHALL have port tx_serial, output, 1: serial line, idle high.
REQ-013 SHALL have port tx_active, output, 1: high from START through last STOP cycle.
REQ-014 SHALL have port tx_done, output, 1: one-cycle pulse after each frame.
REQ-015 SHALL have port fifo_count, output, clog2(FIFO_DEPTH+1): current FIFO occupancy.
REQ-016 SHALL have port overflow, output, 1: one-cycle pulse when a write is dropped.

Function
REQ-017 SHALL accept a write on any edge with tx_dv=1 and FIFO not full.
REQ-018 SHALL drop a write arriving while full, even if a pop occurs in the same cycle, and pulse overflow.
REQ-019 SHALL use states IDLE, START, DATA, PARITY, STOP, DONE, with all outputs registered.
REQ-020 SHALL, in IDLE with FIFO non-empty, pop the head entry and latch data_bits, parity_mode, stop_bits and effective clks_per_bit, then enter START.
REQ-021 SHALL ignore configuration changes until the next frame start.
REQ-022 SHALL start tx_serial low the edge after a write to an empty FIFO while in IDLE (latency 1 cycle).
REQ-023 SHALL hold each START, DATA and PARITY bit for exactly clks_per_bit cycles, using a DIV_W-bit counter that counts 0..clks_per_bit-1 and then wraps.
REQ-024 SHALL send DATA bits LSB first, N bits per data_bits; unused upper tx_byte bits are ignored.
REQ-025 SHALL visit PARITY only when parity_mode is not 0: even gives XOR of the N bits; odd gives its inverse; space gives 0.
REQ-026 SHALL drive STOP high for clks_per_bit cycles, or 2*clks_per_bit when stop_bits=1.
REQ-027 SHALL make DONE one cycle: tx_serial high, tx_active low, tx_done=1, then go to IDLE.
REQ-028 SHALL give back-to-back frames exactly 2 high cycles (DONE+IDLE) between the last stop cycle and the next start bit.
REQ-029 SHALL have total frame length clks_per_bit*(1+N+P+S) cycles; P is 0 or 1, S is 1 or 2.
REQ-030 SHALL let simultaneous push and pop (not full) leave fifo_count unchanged; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-031 SHALL keep tx_serial high and tx_active low in IDLE.

Reset
REQ-032 SHALL, on rst_n=0, immediately set state IDLE, tx_serial=1, tx_active=0, tx_done=0, overflow=0, fifo_count=0, tx_ready=1, and clear counters and pointers.
REQ-033 SHALL abort a frame interrupted by reset and discard all FIFO contents; after release the line stays high until a new write.

Verification
REQ-034 SHALL pass: 0xA5, 8N1, clks_per_bit=4 -> tx_serial 0,1,0,1,0,0,1,0,1,1, each 4 cycles; tx_done 1 cycle after the 40th cycle.
REQ-035 SHALL pass: 0x1F, 5 bits, even parity, 1 stop, clks_per_bit=3 -> 0,1,1,1,1,1,1(parity),1; frame 24 cycles.
REQ-036 SHALL pass: 0x00, 7 bits, odd parity, 2 stop, clks_per_bit=2 -> 0,0000000,1(parity),1,1; stop held 4 cycles.
REQ-037 SHALL pass: depth 4, idle line, 6 consecutive tx_dv writes -> first byte popped, 4 queued, 6th dropped with overflow pulse, tx_ready low while count=4; 5 frames sent, each separated by a 2-cycle gap.
REQ-038 SHALL pass: rst_n low mid-DATA with 2 bytes queued -> tx_serial high at once, fifo_count=0, no tx_done.
REQ-039 SHALL pass: data_bits changed 8->5 mid-frame -> current frame still 8 bits; next frame 5 bits; clks_per_bit=1 -> bits last 2 cycles.

Source files
------------

// File: rtl/uart_tx_gen.sv
// UART transmitter with a small write FIFO and per-frame configuration
// (5..8 data bits, none/even/odd/space parity, one or two stop bits).
module uart_tx_gen #(
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_W      = 16
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             tx_dv,
   input  logic [7:0]                       tx_byte,
   output logic                             tx_ready,
   input  logic [1:0]                       data_bits,
   input  logic [1:0]                       parity_mode,
   input  logic                             stop_bits,
   input  logic [DIV_W-1:0]                 clks_per_bit,
   output logic                             tx_serial,
   output logic                             tx_active,
   output logic                             tx_done,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
   output logic                             overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH+1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

   function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
      return (d < DIV_W'(2)) ? DIV_W'(2) : d;
   endfunction

   function automatic logic par_calc(input logic [7:0] d, input logic [1:0] mode);
      case (mode)
         2'd1:    return ^d;
         2'd2:    return ~^d;
         default: return 1'b0;
      endcase
   endfunction

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count_next;
   logic             full, empty, push, pop;

   state_t           state;
   logic [DIV_W-1:0] bit_cnt, cpb_eff;
   logic [2:0]       bit_idx, n_last;
   logic [7:0]       shreg, head_masked;
   logic [1:0]       par_mode;
   logic             par_bit, two_stop, stop_second, bit_last;

   assign full  = (fifo_count == CNT_W'(FIFO_DEPTH));
   assign empty = (fifo_count == '0);
   // A write while full is dropped even if the FSM pops in the same cycle.
   assign push  = tx_dv & ~full;
   assign pop   = (state == IDLE) & ~empty;

   assign head_masked = mem[rd_ptr] & (8'hFF >> (2'd3 - data_bits));
   assign bit_last    = (bit_cnt == cpb_eff - DIV_W'(1));

   always_comb begin
      count_next = fifo_count;
      case ({push, pop})
         2'b10:   count_next = fifo_count + CNT_W'(1);
         2'b01:   count_next = fifo_count - CNT_W'(1);
         default: count_next = fifo_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= tx_byte;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         tx_ready   <= 1'b1;
         overflow   <= 1'b0;
      end else begin
         overflow   <= tx_dv & full;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_count <= count_next;
         tx_ready   <= (count_next != CNT_W'(FIFO_DEPTH));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         cpb_eff     <= DIV_W'(2);
         bit_idx     <= '0;
         n_last      <= 3'd7;
         shreg       <= '0;
         par_mode    <= '0;
         par_bit     <= 1'b0;
         two_stop    <= 1'b0;
         stop_second <= 1'b0;
         tx_serial   <= 1'b1;
         tx_active   <= 1'b0;
         tx_done     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               tx_serial <= 1'b1;
               tx_active <= 1'b0;
               tx_done   <= 1'b0;
               if (pop) begin
                  // Configuration is frozen here for the whole frame.
                  shreg     <= head_masked;
                  n_last    <= {1'b0, data_bits} + 3'd4;
                  par_mode  <= parity_mode;
                  par_bit   <= par_calc(head_masked, parity_mode);
                  two_stop  <= stop_bits;
                  cpb_eff   <= eff_div(clks_per_bit);
                  bit_cnt   <= '0;
                  tx_serial <= 1'b0;
                  tx_active <= 1'b1;
                  state     <= START;
               end
            end
            START: begin
               if (bit_last) begin
                  bit_cnt   <= '0;
                  bit_idx   <= '0;
                  tx_serial <= shreg[0];
                  shreg     <= shreg >> 1;
                  state     <= DATA;
               end else begin
                  bit_cnt <= bit_cnt + DIV_W'(1);
               end
            end
            DATA: begin
               if (bit_last) begin
                  bit_cnt <= '0;
                  if (bit_idx == n_last) begin
                     stop_second <= 1'b0;
                     if (par_mode != 2'd0) begin
                        tx_serial <= par_bit;
                        state     <= PARITY;
                     end else begin
                        tx_serial <= 1'b1;
                        state     <= STOP;
                     end
                  end else begin
                     bit_idx   <= bit_idx + 3'd1;
                     tx_serial <= shreg[0];
                     shreg     <= shreg >> 1;
                  end
               end else begin
                  bit_cnt <= bit_cnt + DIV_W'(1);
               end
            end
            PARITY: begin
               if (bit_last) begin
                  bit_cnt   <= '0;
                  tx_serial <= 1'b1;
                  state     <= STOP;
               end else begin
                  bit_cnt <= bit_cnt + DIV_W'(1);
               end
            end
            STOP: begin
               if (bit_last) begin
                  bit_cnt <= '0;
                  if (two_stop && !stop_second) begin
                     stop_second <= 1'b1;
                  end else begin
                     tx_active <= 1'b0;
                     tx_done   <= 1'b1;
                     state     <= DONE;
                  end
               end else begin
                  bit_cnt <= bit_cnt + DIV_W'(1);
               end
            end
            DONE: begin
               tx_serial <= 1'b1;
               tx_done   <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_gen.sv
// Bench for uart_tx_gen: directed frames plus randomized bursts, each frame
// compared cycle by cycle against a waveform built from the framing rules.
module tb_uart_tx_gen;

   localparam int DEPTH     = 4;
   localparam int DW        = 16;
   localparam int GAP_LIMIT = 200;

   logic                         clk = 1'b0;
   logic                         rst_n;
   logic                         tx_dv;
   logic [7:0]                   tx_byte;
   logic                         tx_ready;
   logic [1:0]                   data_bits;
   logic [1:0]                   parity_mode;
   logic                         stop_bits;
   logic [DW-1:0]                clks_per_bit;
   logic                         tx_serial;
   logic                         tx_active;
   logic                         tx_done;
   logic [$clog2(DEPTH+1)-1:0]   fifo_count;
   logic                         overflow;

   int         n_checks = 0;
   int         n_err    = 0;
   logic [7:0] bq [8];
   int         burst_len, accepted, bad;

   always #5 clk = ~clk;

   uart_tx_gen #(.FIFO_DEPTH(DEPTH), .DIV_W(DW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .tx_dv        (tx_dv),
      .tx_byte      (tx_byte),
      .tx_ready     (tx_ready),
      .data_bits    (data_bits),
      .parity_mode  (parity_mode),
      .stop_bits    (stop_bits),
      .clks_per_bit (clks_per_bit),
      .tx_serial    (tx_serial),
      .tx_active    (tx_active),
      .tx_done      (tx_done),
      .fifo_count   (fifo_count),
      .overflow     (overflow)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_cfg(input int db, input int pm, input int sb, input int cpb);
      data_bits    = 2'(db);
      parity_mode  = 2'(pm);
      stop_bits    = 1'(sb);
      clks_per_bit = DW'(cpb);
   endtask

   // Waits for a start bit, then compares one whole frame against the
   // expected line waveform; ends on the sample of the post-frame cycle.
   task automatic capture(input string tag, input logic [7:0] b, input int db, input int pm,
                          input int sb, input int cpb, input int exp_gap);
      int ceff, n, s, ones, gap, errs, act, len;
      int bits[$];
      ceff = (cpb < 2) ? 2 : cpb;
      n    = db + 5;
      s    = sb + 1;
      ones = 0;
      bits.push_back(0);
      for (int i = 0; i < n; i++) begin
         bits.push_back(int'(b[i]));
         ones += int'(b[i]);
      end
      if (pm == 1)      bits.push_back(ones % 2);
      else if (pm == 2) bits.push_back(1 - ones % 2);
      else if (pm == 3) bits.push_back(0);
      for (int i = 0; i < s; i++) bits.push_back(1);
      len  = ceff * bits.size();
      gap  = 0;
      errs = 0;
      while (tx_serial !== 1'b0 && gap < GAP_LIMIT) begin
         if (gap > 0 && tx_done !== 1'b0) errs++;
         if (tx_active !== 1'b0) errs++;
         gap++;
         @(negedge clk);
      end
      check_eq({tag, ".gap"}, gap, exp_gap);
      if (gap >= GAP_LIMIT) return;
      act = 0;
      for (int c = 0; c < len; c++) begin
         if (tx_serial !== 1'(bits[c / ceff])) errs++;
         if (tx_done !== 1'b0) errs++;
         if (tx_active === 1'b1) act++;
         @(negedge clk);
      end
      check_eq({tag, ".wave"}, errs, 0);
      check_eq({tag, ".len"}, act, ceff * (1 + n + int'(pm != 0) + s));
      check_eq({tag, ".done"}, {tx_serial, tx_active, tx_done}, 3'b101);
   endtask

   // Consecutive writes onto an idle line: the first byte is popped on the
   // next edge, so occupancy lags the write count by one until full.
   task automatic drive_burst(input string tag, input int len);
      int exp_cnt;
      for (int k = 1; k <= len; k++) begin
         tx_dv   = 1'b1;
         tx_byte = bq[k-1];
         @(negedge clk);
         exp_cnt = (k == 1) ? 1 : ((k - 1 < DEPTH) ? k - 1 : DEPTH);
         check_eq({tag, ".count"}, fifo_count, exp_cnt);
         check_eq({tag, ".ready"}, tx_ready, exp_cnt != DEPTH);
         check_eq({tag, ".ovf"}, overflow, k > DEPTH + 1);
      end
      tx_dv = 1'b0;
      @(negedge clk);
      check_eq({tag, ".ovf_end"}, overflow, 0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      tx_dv   = 1'b0;
      tx_byte = 8'h00;
      set_cfg(3, 0, 0, 4);
      repeat (3) @(negedge clk);
      check_eq("rst.serial", tx_serial, 1);
      check_eq("rst.active", tx_active, 0);
      check_eq("rst.done", tx_done, 0);
      check_eq("rst.ovf", overflow, 0);
      check_eq("rst.count", fifo_count, 0);
      check_eq("rst.ready", tx_ready, 1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 0xA5, 8N1, 4 clocks per bit
      bq[0] = 8'hA5;
      fork
         capture("a5_8n1", 8'hA5, 3, 0, 0, 4, 2);
         drive_burst("a5_wr", 1);
      join
      @(negedge clk);

      // 0x1F, 5 bits, even parity, 3 clocks per bit
      set_cfg(0, 1, 0, 3);
      bq[0] = 8'h1F;
      fork
         capture("1f_5e1", 8'h1F, 0, 1, 0, 3, 2);
         drive_burst("1f_wr", 1);
      join
      @(negedge clk);

      // 0x00, 7 bits, odd parity, two stop bits, 2 clocks per bit
      set_cfg(2, 2, 1, 2);
      bq[0] = 8'h00;
      fork
         capture("00_7o2", 8'h00, 2, 2, 1, 2, 2);
         drive_burst("00_wr", 1);
      join
      @(negedge clk);

      // Six writes into a depth-4 FIFO: five frames, last write dropped
      set_cfg(3, 0, 0, 4);
      for (int i = 0; i < 6; i++) bq[i] = 8'($urandom_range(0, 255));
      fork
         for (int j = 0; j < 5; j++) capture("burst6", bq[j], 3, 0, 0, 4, 2);
         drive_burst("burst6_wr", 6);
      join
      @(negedge clk);

      // Reset in the middle of a data bit with two bytes still queued
      for (int i = 0; i < 3; i++) bq[i] = 8'($urandom_range(0, 255));
      drive_burst("rstmid_wr", 3);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rstmid.serial", tx_serial, 1);
      check_eq("rstmid.active", tx_active, 0);
      check_eq("rstmid.count", fifo_count, 0);
      check_eq("rstmid.ready", tx_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (60) begin
         @(negedge clk);
         if (tx_serial !== 1'b1 || tx_done !== 1'b0 || tx_active !== 1'b0 || fifo_count != 0) bad++;
      end
      check_eq("rstmid.quiet", bad, 0);

      // data_bits changed mid-frame; clks_per_bit=1 behaves as 2
      set_cfg(3, 0, 0, 1);
      bq[0] = 8'($urandom_range(0, 255));
      bq[1] = 8'($urandom_range(0, 255));
      fork
         begin
            capture("cfg_f1", bq[0], 3, 0, 0, 1, 2);
            capture("cfg_f2", bq[1], 0, 0, 0, 1, 2);
         end
         begin
            drive_burst("cfg_wr", 2);
            repeat (6) @(negedge clk);
            data_bits = 2'd0;
         end
      join
      @(negedge clk);

      // Randomized bursts under random configurations
      for (int r = 0; r < 8; r++) begin
         set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
         burst_len = int'($urandom_range(1, DEPTH + 2));
         accepted  = (burst_len < DEPTH + 1) ? burst_len : DEPTH + 1;
         for (int i = 0; i < burst_len; i++) bq[i] = 8'($urandom);
         @(negedge clk);
         fork
            for (int j = 0; j < accepted; j++)
               capture($sformatf("rnd%0d_f%0d", r, j), bq[j], int'(data_bits),
                       int'(parity_mode), int'(stop_bits), int'(clks_per_bit), 2);
            drive_burst($sformatf("rnd%0d_wr", r), burst_len);
         join
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
